// File: rtl/disp_share_ctrl_pkg.sv
// disp_pkg: shared constants, FSM state encoding and the BCD to 7-segment decoder
// used by the display-sharing controller and its scan sub-module.
//   SEG_0..SEG_9 : segment patterns (a..g,dp MSB-first, active-high)
//   SEG_BLANK    : all segments off
//   SEL_OFF      : no digit enabled (active-low enables)
//   state_t      : FSM state type with IDLE / OWN / SWITCH constants
//   seg_decode() : BCD nibble -> segment pattern, non-BCD nibbles blank
package disp_pkg;

  localparam logic [7:0] SEG_0     = 8'hFC;
  localparam logic [7:0] SEG_1     = 8'h60;
  localparam logic [7:0] SEG_2     = 8'hDA;
  localparam logic [7:0] SEG_3     = 8'hF2;
  localparam logic [7:0] SEG_4     = 8'h66;
  localparam logic [7:0] SEG_5     = 8'hB6;
  localparam logic [7:0] SEG_6     = 8'hBE;
  localparam logic [7:0] SEG_7     = 8'hE0;
  localparam logic [7:0] SEG_8     = 8'hFE;
  localparam logic [7:0] SEG_9     = 8'hF6;
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [3:0] SEL_OFF   = 4'b1111;

  typedef logic [1:0] state_t;
  localparam state_t IDLE   = 2'd0;
  localparam state_t OWN    = 2'd1;
  localparam state_t SWITCH = 2'd2;

  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    logic [7:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/disp_share_ctrl_seg_scan.sv
// seg_scan: digit multiplexer for the 4-digit 7-segment display.
// Steps through digits 0..3, holding each for SCAN_DIV enabled cycles, and
// registers the decoded segment pattern and digit enable one cycle after the
// (en, digit, word) values they are derived from.
//   clock, reset : rising-edge clock, asynchronous active-low reset
//   en           : display owned; counters run and outputs show the word
//   restart      : ownership begins next edge; counters return to digit 0
//   word[15:0]   : BCD word being shown, digit3 in the MSB nibble
//   seg[7:0]     : segment pattern, active-high
//   sel[3:0]     : digit enables, active-low (4'b1110 = digit0)
module seg_scan
  import disp_pkg::*;
#(
  parameter int SCAN_DIV = 32
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic        restart,
  input  logic [15:0] word,
  output logic [7:0]  seg,
  output logic [3:0]  sel
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] scan_cnt;
  logic [1:0]    digit;
  logic [3:0]    nibble;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (restart) begin
      scan_cnt <= '0;
      digit    <= 2'd0;
    end else if (en) begin
      if (scan_cnt == CNT_MAX) begin
        scan_cnt <= '0;
        digit    <= digit + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
    end
  end

  // The word is taken live every cycle so an owner can update its value
  // while it holds the display.
  always_comb begin
    case (digit)
      2'd0:    nibble = word[3:0];
      2'd1:    nibble = word[7:4];
      2'd2:    nibble = word[11:8];
      default: nibble = word[15:12];
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg <= SEG_BLANK;
      sel <= SEL_OFF;
    end else if (en) begin
      seg <= seg_decode(nibble);
      sel <= ~(4'b0001 << digit);
    end else begin
      seg <= SEG_BLANK;
      sel <= SEL_OFF;
    end
  end

endmodule

// File: rtl/disp_share_ctrl.sv
// disp_share_ctrl: time-shares one 4-digit multiplexed 7-segment display
// between NREQ requesters using round-robin arbitration with time slicing.
// An owner keeps the display until it drops req, or until it has held it
// for SLICE cycles while someone else is waiting. Each handover passes
// through one blank SWITCH cycle.
//   reset        : asynchronous, active-low
//   clock        : rising edge
//   req[NREQ]    : level request per requester, held while in use
//   data[16*NREQ]: BCD word of requester i at [16*i+15:16*i]
//   grant[NREQ]  : one-hot (or zero) owner indication, registered
//   seg[7:0]     : segments a..g,dp MSB-first, active-high, registered
//   sel[3:0]     : digit enables, active-low, registered
module disp_share_ctrl
  import disp_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int SCAN_DIV = 32,
  parameter int SLICE    = 1024
) (
  input  logic                 reset,
  input  logic                 clock,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   data,
  output logic [NREQ-1:0]      grant,
  output logic [7:0]           seg,
  output logic [3:0]           sel
);

  localparam int IW = $clog2(NREQ);
  localparam int SW = $clog2(SLICE);
  localparam logic [SW-1:0] SLICE_MAX = SW'(SLICE - 1);
  localparam logic [IW:0]   NREQ_W    = (IW+1)'(NREQ);

  state_t          state;
  state_t          state_n;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   owner_n;
  logic [IW-1:0]   rr_ptr;
  logic [IW-1:0]   rr_ptr_n;
  logic [SW-1:0]   slice_cnt;
  logic [SW-1:0]   slice_n;
  logic [NREQ-1:0] grant_n;

  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic              found;
  logic [IW-1:0]     offset;
  logic [IW:0]       win_sum;
  logic [IW-1:0]     winner;
  logic [NREQ-1:0]   win_onehot;

  logic              owner_req;
  logic              other_req;
  logic              slice_done;
  logic              restart;
  logic              en;
  logic [15:0]       word;

  // Round-robin search: rotate req so that bit 0 is the requester at rr_ptr,
  // take the lowest set bit, then map the offset back to an index mod NREQ.
  always_comb begin
    req_dbl = {req, req} >> rr_ptr;
    req_rot = req_dbl[NREQ-1:0];
    found   = 1'b0;
    offset  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_rot[k]) begin
        found  = 1'b1;
        offset = IW'(k);
      end
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, offset};
    if (win_sum >= NREQ_W) begin
      win_sum = win_sum - NREQ_W;
    end
    winner = win_sum[IW-1:0];
    win_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_onehot[i] = (winner == IW'(i));
    end
  end

  // grant is one-hot of owner while in OWN, so it doubles as the owner mask.
  assign owner_req  = |(req & grant);
  assign other_req  = |(req & ~grant);
  assign slice_done = (slice_cnt == SLICE_MAX);

  always_comb begin
    word = 16'h0000;
    for (int i = 0; i < NREQ; i++) begin
      if (owner == IW'(i)) begin
        word = data[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_n  = state;
    owner_n  = owner;
    rr_ptr_n = rr_ptr;
    slice_n  = slice_cnt;
    grant_n  = grant;
    restart  = 1'b0;
    case (state)
      OWN: begin
        if (!slice_done) begin
          slice_n = slice_cnt + 1'b1;
        end
        // Release by the owner wins over preemption; both hand over the same way.
        if (!owner_req || (slice_done && other_req)) begin
          state_n  = SWITCH;
          grant_n  = '0;
          rr_ptr_n = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
        end
      end
      default: begin
        // IDLE and SWITCH arbitrate identically; in SWITCH rr_ptr already
        // points past the releasing owner, making it lowest priority.
        if (found) begin
          state_n = OWN;
          owner_n = winner;
          grant_n = win_onehot;
          slice_n = '0;
          restart = 1'b1;
        end else begin
          state_n = IDLE;
          grant_n = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      slice_cnt <= '0;
      grant     <= '0;
    end else begin
      state     <= state_n;
      owner     <= owner_n;
      rr_ptr    <= rr_ptr_n;
      slice_cnt <= slice_n;
      grant     <= grant_n;
    end
  end

  assign en = (state == OWN);

  seg_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_seg_scan (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .restart (restart),
    .word    (word),
    .seg     (seg),
    .sel     (sel)
  );

  grant_onehot: assert property (@(posedge clock) disable iff (!reset) $onehot0(grant));

endmodule

// File: tb/tb_disp_share_ctrl.sv
// Bench for disp_share_ctrl (NREQ=2, SCAN_DIV=4, SLICE=8): directed scenarios
// followed by random req/data traffic, all compared against a reference model
// that tracks ownership, elapsed ownership time and the round-robin pointer.
module tb_disp_share_ctrl;

  localparam int NREQ     = 2;
  localparam int SCAN_DIV = 4;
  localparam int SLICE    = 8;

  logic                 clock = 1'b0;
  logic                 reset = 1'b0;
  logic [NREQ-1:0]      req   = '0;
  logic [16*NREQ-1:0]   data  = '0;
  logic [NREQ-1:0]      grant;
  logic [7:0]           seg;
  logic [3:0]           sel;

  always #5 clock = ~clock;

  disp_share_ctrl #(
    .NREQ     (NREQ),
    .SCAN_DIV (SCAN_DIV),
    .SLICE    (SLICE)
  ) dut (
    .reset (reset),
    .clock (clock),
    .req   (req),
    .data  (data),
    .grant (grant),
    .seg   (seg),
    .sel   (sel)
  );

  int checks = 0;
  int errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: mode 0 = nobody owns, 1 = owned, 2 = blank handover cycle.
  logic [7:0] seg_tab [0:9] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
  int              m_mode;
  int              m_owner;
  int              m_held;
  int              m_ptr;
  logic [NREQ-1:0] e_grant;
  logic [7:0]      e_seg;
  logic [3:0]      e_sel;

  function automatic logic [7:0] ref_decode(input logic [3:0] n);
    if (n < 4'd10) return seg_tab[n];
    return 8'h00;
  endfunction

  function automatic bit req_bit(input logic [NREQ-1:0] r, input int i);
    return ((r >> i) & NREQ'(1)) != '0;
  endfunction

  task automatic model_reset();
    m_mode  = 0;
    m_owner = 0;
    m_held  = 0;
    m_ptr   = 0;
    e_grant = '0;
    e_seg   = 8'h00;
    e_sel   = 4'b1111;
  endtask

  // Advances the model over one rising edge using the inputs currently driven.
  task automatic model_edge();
    int         d;
    logic [15:0] w;
    bit         others;
    bit         got;
    int         cand;
    if (m_mode == 1) begin
      d     = (m_held / SCAN_DIV) % 4;
      w     = data[16*m_owner +: 16];
      e_sel = ~(4'b0001 << d);
      e_seg = ref_decode(w[4*d +: 4]);
    end else begin
      e_sel = 4'b1111;
      e_seg = 8'h00;
    end
    if (m_mode == 1) begin
      others = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        if (i != m_owner && req_bit(req, i)) others = 1'b1;
      end
      if (!req_bit(req, m_owner) || (m_held >= SLICE - 1 && others)) begin
        m_mode = 2;
        m_ptr  = (m_owner + 1) % NREQ;
      end else begin
        m_held++;
      end
    end else begin
      got = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
        cand = (m_ptr + k) % NREQ;
        if (!got && req_bit(req, cand)) begin
          got     = 1'b1;
          m_owner = cand;
        end
      end
      m_mode = got ? 1 : 0;
      m_held = 0;
    end
    e_grant = (m_mode == 1) ? (NREQ'(1) << m_owner) : '0;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clock);
    #1;
    check_val("grant", 32'(grant), 32'(e_grant));
    check_val("sel", 32'(sel), 32'(e_sel));
    check_val("seg", 32'(seg), 32'(e_seg));
  endtask

  logic [7:0] nbcd_exp [0:3] = '{8'hFC, 8'h00, 8'hF6, 8'h00};

  initial begin
    model_reset();

    // Held in reset with both requesting: nothing granted, display dark.
    reset = 1'b0;
    req   = 2'b11;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_grant", 32'(grant), 32'h0);
    check_val("rst_sel", 32'(sel), 32'hF);
    check_val("rst_seg", 32'(seg), 32'h00);
    reset = 1'b1;
    cycle();
    check_val("first_grant", 32'(grant), 32'h1);

    // Constant contention: owners alternate every SLICE cycles.
    repeat (40) cycle();

    // Drain to idle, then a sole requester showing 1234.
    req = 2'b00;
    repeat (3) cycle();
    data[15:0] = 16'h1234;
    req = 2'b01;
    repeat (40) cycle();

    // Owner 0 releases as requester 1 arrives: 01 -> 00 -> 10.
    req = 2'b10;
    cycle();
    check_val("rel_blank", 32'(grant), 32'h0);
    cycle();
    check_val("rel_new", 32'(grant), 32'h2);
    repeat (5) cycle();

    // Non-BCD nibbles are blanked.
    req = 2'b00;
    repeat (3) cycle();
    data[15:0] = 16'hA9F0;
    req = 2'b01;
    cycle();
    for (int dg = 0; dg < 4; dg++) begin
      for (int s = 0; s < SCAN_DIV; s++) begin
        cycle();
        if (s == 0) check_val("nbcd_seg", 32'(seg), 32'(nbcd_exp[dg]));
      end
    end

    // Asynchronous reset in the middle of requester 1's slice.
    req = 2'b10;
    repeat (6) cycle();
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_grant", 32'(grant), 32'h0);
    check_val("arst_sel", 32'(sel), 32'hF);
    check_val("arst_seg", 32'(seg), 32'h00);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    cycle();
    check_val("arst_regrant", 32'(grant), 32'h2);
    cycle();
    check_val("arst_digit0", 32'(sel), 32'hE);

    // Random traffic.
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        req[$urandom_range(0, NREQ - 1)] ^= 1'b1;
      end
      if ($urandom_range(0, 3) == 0) begin
        for (int b = 0; b < 4 * NREQ; b++) begin
          if ($urandom_range(0, 3) != 0) data[4*b +: 4] = 4'($urandom_range(0, 9));
          else                           data[4*b +: 4] = 4'($urandom_range(10, 15));
        end
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
